// File: rtl/dds_step_monitor_if.sv
// Sample, step-strobe and result-record signals between the DDS path and dds_step_monitor.
// The slave modport is the monitor's view; master is the surrounding environment.
interface dds_step_monitor_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic                            s_axis_data_tvalid;
  logic signed [DATA_W-1:0]        s_axis_data_tdata;
  logic                            s_axis_data_tready;
  logic                            step_end;
  logic                            m_axis_res_tvalid;
  logic                            m_axis_res_tready;
  logic [2*DATA_W+2*CNT_W-1:0]     m_axis_res_tdata;
  logic                            m_axis_res_tlast;
  logic                            overflow;

  modport slave (
    input  s_axis_data_tvalid, s_axis_data_tdata, step_end, m_axis_res_tready,
    output s_axis_data_tready, m_axis_res_tvalid, m_axis_res_tdata, m_axis_res_tlast, overflow
  );

  modport master (
    output s_axis_data_tvalid, s_axis_data_tdata, step_end, m_axis_res_tready,
    input  s_axis_data_tready, m_axis_res_tvalid, m_axis_res_tdata, m_axis_res_tlast, overflow
  );
endinterface

// File: rtl/dds_step_monitor.sv
// Per-step min/max/sample-count/rising-zero-crossing statistics of the DDS sine output,
// one result record per step_end strobe, held in a single-entry AXI-Stream output register.
module dds_step_monitor #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  dds_step_monitor_if.slave bus
);
  localparam int              REC_W   = 2*DATA_W + 2*CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {WAIT_FIRST, RUN} acc_state_t;
  typedef enum logic {EMPTY, FULL}     out_state_t;

  acc_state_t               acc_state;
  out_state_t               out_state;
  logic signed [DATA_W-1:0] min_q, max_q, prev_q;
  logic [CNT_W-1:0]         cnt_q, zc_q;
  logic [REC_W-1:0]         res_q;
  logic                     overflow_q;
  logic                     tready_q;

  logic signed [DATA_W-1:0] sample;
  logic                     accept;
  logic                     handshake;
  logic signed [DATA_W-1:0] f_min, f_max;
  logic [CNT_W-1:0]         f_cnt, f_zc;

  assign sample    = bus.s_axis_data_tdata;
  assign accept    = bus.s_axis_data_tvalid & tready_q;
  assign handshake = (out_state == FULL) & bus.m_axis_res_tready;

  // Accumulators with this cycle's sample folded in; also the snapshot value on step_end.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    f_min = min_q;
    f_max = max_q;
    f_cnt = cnt_q;
    f_zc  = zc_q;
    if (accept) begin
      if (acc_state == WAIT_FIRST) begin
        f_min = sample;
        f_max = sample;
        f_cnt = CNT_W'(1);
        f_zc  = '0;
      end else begin
        if (sample < min_q) f_min = sample;
        if (sample > max_q) f_max = sample;
        if (cnt_q != CNT_MAX) f_cnt = cnt_q + CNT_W'(1);
        // Rising crossing: previous strictly negative, current zero or positive.
        if (prev_q[DATA_W-1] && !sample[DATA_W-1] && (zc_q != CNT_MAX))
          f_zc = zc_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_state  <= WAIT_FIRST;
      out_state  <= EMPTY;
      min_q      <= '0;
      max_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      zc_q       <= '0;
      res_q      <= '0;
      overflow_q <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      tready_q <= 1'b1;

      if (bus.step_end) begin
        acc_state <= WAIT_FIRST;
        min_q     <= '0;
        max_q     <= '0;
        prev_q    <= '0;
        cnt_q     <= '0;
        zc_q      <= '0;
      end else if (accept) begin
        acc_state <= RUN;
        min_q     <= f_min;
        max_q     <= f_max;
        prev_q    <= sample;
        cnt_q     <= f_cnt;
        zc_q      <= f_zc;
      end

      case (out_state)
        EMPTY: begin
          if (bus.step_end) begin
            res_q     <= {f_zc, f_cnt, f_max, f_min};
            out_state <= FULL;
          end
        end
        FULL: begin
          if (bus.step_end) begin
            // A record still held with no handshake this cycle wins; the new one is lost.
            if (handshake) res_q      <= {f_zc, f_cnt, f_max, f_min};
            else           overflow_q <= 1'b1;
          end else if (handshake) begin
            out_state <= EMPTY;
          end
        end
        default: out_state <= EMPTY;
      endcase
    end
  end

  assign bus.s_axis_data_tready = tready_q;
  assign bus.m_axis_res_tvalid  = (out_state == FULL);
  assign bus.m_axis_res_tlast   = (out_state == FULL);
  assign bus.m_axis_res_tdata   = res_q;
  assign bus.overflow           = overflow_q;
endmodule

// File: tb/tb_dds_step_monitor.sv
// Scoreboard bench for dds_step_monitor: a sample-list reference model queues expected
// records; a negedge monitor compares every presented record and the status outputs.
module tb_dds_step_monitor;
  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int RW  = 2*DW + 2*CW;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dds_step_monitor_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  dds_step_monitor #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference state
  int              cur_q[$];
  logic [RW-1:0]   exp_q[$];
  bit              out_full_m = 1'b0;
  bit              ovf_m      = 1'b0;
  bit              rdy_m      = 1'b0;
  bit              zero_m     = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack(input int mn, input int mx, input int cnt, input int zc);
    logic [DW-1:0] a, b;
    logic [CW-1:0] c, z;
    a = mn[DW-1:0];
    b = mx[DW-1:0];
    c = cnt[CW-1:0];
    z = zc[CW-1:0];
    return {z, c, b, a};
  endfunction

  // Statistics of the closed step computed directly from the list of its samples.
  function automatic logic [RW-1:0] model_record();
    int mn, mx, cnt, zc;
    if (cur_q.size() == 0) return '0;
    mn = cur_q[0];
    mx = cur_q[0];
    zc = 0;
    foreach (cur_q[i]) begin
      if (cur_q[i] < mn) mn = cur_q[i];
      if (cur_q[i] > mx) mx = cur_q[i];
      if (i > 0 && cur_q[i-1] < 0 && cur_q[i] >= 0 && zc < SAT) zc++;
    end
    cnt = (cur_q.size() > SAT) ? SAT : cur_q.size();
    return pack(mn, mx, cnt, zc);
  endfunction

  task automatic model_edge();
    bit hs;
    if (!reset) begin
      cur_q.delete();
      exp_q.delete();
      out_full_m = 1'b0;
      ovf_m      = 1'b0;
      rdy_m      = 1'b0;
      zero_m     = 1'b1;
    end else begin
      hs = out_full_m && bus.m_axis_res_tready;
      if (bus.s_axis_data_tvalid && rdy_m) cur_q.push_back(int'(bus.s_axis_data_tdata));
      if (bus.step_end) begin
        if (!out_full_m || hs) begin
          exp_q.push_back(model_record());
          out_full_m = 1'b1;
          zero_m     = 1'b0;
        end else begin
          ovf_m = 1'b1;
        end
        cur_q.delete();
      end else if (hs) begin
        out_full_m = 1'b0;
      end
      rdy_m = 1'b1;
    end
  endtask

  task automatic cycle(input bit v, input int d, input bit se, input bit rdy, input bit rst_n = 1'b1);
    bus.s_axis_data_tvalid = v;
    bus.s_axis_data_tdata  = d[DW-1:0];
    bus.step_end           = se;
    bus.m_axis_res_tready  = rdy;
    reset                  = rst_n;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares outputs mid-cycle and retires a record when it is handshaken.
  initial begin
    forever begin
      @(negedge clk);
      check("s_tready", bus.s_axis_data_tready, rdy_m);
      check("res_tvalid", bus.m_axis_res_tvalid, out_full_m);
      check("res_tlast", bus.m_axis_res_tlast, out_full_m);
      check("overflow", bus.overflow, ovf_m);
      if (out_full_m) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          check("res_tdata", bus.m_axis_res_tdata, exp_q[0]);
          if (bus.m_axis_res_tready) void'(exp_q.pop_front());
        end
      end else if (zero_m) begin
        check("res_tdata_reset", bus.m_axis_res_tdata, '0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata  = '0;
    bus.step_end           = 1'b0;
    bus.m_axis_res_tready  = 1'b0;

    // Reset
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("rst_tvalid", bus.m_axis_res_tvalid, 1'b0);
    check("rst_tdata", bus.m_axis_res_tdata, '0);
    check("rst_tready", bus.s_axis_data_tready, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("rel_tready", bus.s_axis_data_tready, 1'b1);

    // Basic step
    cycle(1'b1, -100, 1'b0, 1'b1);
    cycle(1'b1,   50, 1'b0, 1'b1);
    cycle(1'b1,  -20, 1'b0, 1'b1);
    cycle(1'b1,   30, 1'b0, 1'b1);
    cycle(1'b1,    0, 1'b0, 1'b1);
    cycle(1'b0,    0, 1'b1, 1'b1);
    check("basic_valid", bus.m_axis_res_tvalid, 1'b1);
    check("basic_rec", bus.m_axis_res_tdata, pack(-100, 50, 5, 2));
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("basic_clear", bus.m_axis_res_tvalid, 1'b0);

    // Same-cycle close, then snapshot during handshake (empty step), then back-to-back empty
    cycle(1'b1, 10, 1'b0, 1'b1);
    cycle(1'b1, -5, 1'b0, 1'b1);
    cycle(1'b1,  7, 1'b1, 1'b1);
    check("samecyc_rec", bus.m_axis_res_tdata, pack(-5, 10, 3, 1));
    cycle(1'b0, 0, 1'b1, 1'b1);
    check("hs_snap_valid", bus.m_axis_res_tvalid, 1'b1);
    check("hs_snap_ovf", bus.overflow, 1'b0);
    check("empty_rec", bus.m_axis_res_tdata, '0);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check("empty_rec2", bus.m_axis_res_tdata, '0);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Counter saturation: 20 alternating +1/-1 samples
    for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2 == 0) ? 1 : -1, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check("sat_rec", bus.m_axis_res_tdata, pack(-1, 1, 15, 9));
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Backpressure and overflow
    cycle(1'b1,  300, 1'b0, 1'b0);
    cycle(1'b1, -300, 1'b0, 1'b0);
    cycle(1'b0,    0, 1'b1, 1'b0);
    cycle(1'b1,    5, 1'b0, 1'b0);
    cycle(1'b1,   -6, 1'b0, 1'b0);
    cycle(1'b0,    0, 1'b1, 1'b0);
    check("bp_ovf", bus.overflow, 1'b1);
    check("bp_held", bus.m_axis_res_tdata, pack(-300, 300, 2, 0));
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("bp_drained", bus.m_axis_res_tvalid, 1'b0);
    check("bp_ovf_sticky", bus.overflow, 1'b1);

    // Reset mid-step with a record pending
    cycle(1'b1,  1000, 1'b0, 1'b0);
    cycle(1'b1, -2000, 1'b0, 1'b0);
    cycle(1'b0,     0, 1'b1, 1'b0);
    cycle(1'b1, -3000, 1'b0, 1'b0);
    cycle(1'b1,     0, 1'b0, 1'b0, 1'b0);
    check("mrst_tvalid", bus.m_axis_res_tvalid, 1'b0);
    check("mrst_tdata", bus.m_axis_res_tdata, '0);
    check("mrst_ovf", bus.overflow, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b1,  40, 1'b0, 1'b1);
    cycle(1'b1, -40, 1'b0, 1'b1);
    cycle(1'b0,   0, 1'b1, 1'b1);
    check("mrst_rec", bus.m_axis_res_tdata, pack(-40, 40, 2, 0));
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [DW-1:0] r;
      int d;
      r = DW'($urandom);
      d = ($urandom_range(0, 3) == 0) ? $signed(r) : (int'($urandom_range(0, 20)) - 10);
      cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6);
    end

    // Drain
    for (int n = 0; n < 3; n++) cycle(1'b0, 0, 1'b0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dds_step_monitor.md
# dds_step_monitor

Measures the DDS compiler sine output for each frequency step of the sweep and emits one result record per step on an AXI-Stream master. It sits directly downstream of the DDS compiler, which is fed by the phase-increment sweep state machine, and uses that state machine's step-end strobe (its tlast pulse) to close each measurement window. Per step it reports the minimum sample, the maximum sample, the sample count and the rising zero-crossing count, for frequency and amplitude checking on hardware.

## Interface
- DATA_W, 16, signed sample width of the DDS sine output
- CNT_W, 16, width of the per-step sample and zero-crossing counters (both saturate)

- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low (reset == 0 resets)
- s_axis_data_tvalid  in  1  DDS output sample valid
- s_axis_data_tdata  in  DATA_W  DDS sine sample, two's complement
- s_axis_data_tready  out  1  always 1 after reset (the DDS path has no backpressure)
- step_end  in  1  one-cycle strobe from the phase sweep state machine that closes the current step
- m_axis_res_tvalid  out  1  result record valid
- m_axis_res_tready  in  1  result consumer ready
- m_axis_res_tdata  out  2*DATA_W+2*CNT_W  {zc_cnt, sample_cnt, max, min}, with min in the LSBs
- m_axis_res_tlast  out  1  equals m_axis_res_tvalid (every record is a one-beat packet)
- overflow  out  1  sticky flag: a step result was dropped

## Operation
- **Accumulator FSM:**
  - WAIT_FIRST: no sample taken yet in the current step.
    - On an accepted sample (tvalid=1): min = max = sample, sample_cnt = 1, zc_cnt = 0, prev = sample. Go to RUN.
  - RUN: on each accepted sample:
    - min = smaller of (min, sample) and max = larger of (max, sample), signed compare.
    - sample_cnt increments and saturates at 2^CNT_W−1.
    - zc_cnt increments (saturating) when prev < 0 and sample ≥ 0.
    - prev = sample.
- **Step close:** step_end=1 snapshots the accumulators into the result register and returns the FSM to WAIT_FIRST.
  - If a sample is accepted in the same cycle, that sample belongs to the closing step and is folded into the snapshot.
  - If step_end occurs in WAIT_FIRST, the record is min=0, max=0, sample_cnt=0, zc_cnt=0 and is still emitted.
- **Output register FSM:**
  - EMPTY → FULL on a snapshot; m_axis_res_tvalid=1 while FULL.
  - FULL → EMPTY when tvalid & tready.
  - Snapshot while FULL with no handshake that cycle: the new record is discarded, the held record is unchanged and overflow is set.
  - Snapshot in the same cycle as the handshake: the new record loads and tvalid stays 1, with no overflow.
- Accumulation never stalls; output backpressure affects only the result register.
- overflow clears only on reset.

## Timing
- **Reset** (synchronous, reset==0 at a clk edge):
  - Accumulator FSM = WAIT_FIRST; output register FSM = EMPTY.
  - m_axis_res_tvalid=0, m_axis_res_tlast=0, m_axis_res_tdata=0, overflow=0.
  - All accumulators = 0.
  - s_axis_data_tready=0 while reset is held, and 1 from the first cycle after release.
  - Reset asserted mid-step or with a record pending discards everything without emitting.
- **Latency:** step_end sampled at edge N gives m_axis_res_tvalid=1 after edge N (visible in cycle N+1). m_axis_res_tdata is stable while tvalid=1 and tready=0.
- **Counters:** the sample following a step_end is the first sample of the new step. No zero crossing is counted across a step boundary, because prev is invalid in WAIT_FIRST.
- **Arithmetic:**
  - min/max are signed DATA_W values.
  - Counters are unsigned CNT_W and hold at all-ones once saturated, with no wrap.
  - Sample value 0 counts as non-negative.

## Test plan
- **Basic step:** after reset, drive samples −100, 50, −20, 30, 0, then step_end. Required record: min=−100, max=50, sample_cnt=5, zc_cnt=2. tvalid rises 1 cycle after step_end and tready=1 clears it.
- **Same-cycle close:** samples 10, −5, then sample 7 driven together with step_end. Required: min=−5, max=10, sample_cnt=3, zc_cnt=1. The next step starts empty.
- **Backpressure and overflow:** hold tready=0 across two step_end strobes. Required: the first record is held unchanged and the second is dropped, overflow=1. After tready=1 only the first record is delivered and overflow stays 1.
- **Simultaneous handshake and snapshot:** step_end arrives in the same cycle as tvalid&tready. Required: the new record loads, tvalid stays 1, overflow=0.
- **Empty step and saturation:**
  - Two back-to-back step_end strobes with no samples between them. Required: the second record is all zeros.
  - With CNT_W=4, 20 alternating ±1 samples. Required: sample_cnt=15, zc_cnt=9 (not saturated).
- **Reset mid-step:** assert reset==0 for one cycle during RUN with a record pending. Required: all outputs are 0, no record is emitted, and the next step's statistics exclude the pre-reset samples.
